// File: rtl/run_pkg.sv
// Shared types and constants for the run_monitor block: FSM state encoding and PC width.
package run_pkg;

    localparam int PC_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        RESET,
        RUN,
        DRAIN,
        DONE
    } run_state_t;

endpackage

// File: rtl/run_monitor_if.sv
// Harness-facing bundle of the run monitor: run control, per-core halt inputs and run status.
interface run_monitor_if import run_pkg::*; #(
    parameter int NUM_CORES = 1,
    parameter int CNT_W     = 32
);

    logic                      start;
    logic [NUM_CORES-1:0]      hlt;
    logic [PC_W*NUM_CORES-1:0] pc;

    logic                      cpu_rst_n;
    logic                      running;
    logic                      done;
    logic                      timeout;
    logic [CNT_W-1:0]          cycle_cnt;
    logic [NUM_CORES-1:0]      halted;
    logic [PC_W*NUM_CORES-1:0] halt_pc;

    // Harness side: drives run control and core halt/PC, observes status.
    modport master (
        output start, hlt, pc,
        input  cpu_rst_n, running, done, timeout, cycle_cnt, halted, halt_pc
    );

    // Monitor side.
    modport slave (
        input  start, hlt, pc,
        output cpu_rst_n, running, done, timeout, cycle_cnt, halted, halt_pc
    );

endinterface

// File: rtl/halt_tracker.sv
// Per-core sticky halt flag with the PC captured on the first halt seen while enabled.
module halt_tracker import run_pkg::*; (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            enable,
    input  logic            hlt,
    input  logic [PC_W-1:0] pc,
    output logic            halted,
    output logic            halted_next,
    output logic [PC_W-1:0] halt_pc
);

    logic capture;

    assign capture     = enable && hlt && !halted;
    assign halted_next = halted || capture;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted  <= 1'b0;
            halt_pc <= '0;
        end else if (clear) begin
            halted  <= 1'b0;
            halt_pc <= '0;
        end else if (capture) begin
            halted  <= 1'b1;
            halt_pc <= pc;
        end
    end

endmodule

// File: rtl/run_monitor.sv
// Run controller: sequences core reset, counts RUN cycles, tracks per-core halts and an optional watchdog.
module run_monitor import run_pkg::*; #(
    parameter int NUM_CORES    = 1,
    parameter int RST_CYCLES   = 1,
    parameter int DRAIN_CYCLES = 1,
    parameter int TIMEOUT      = 0,
    parameter int CNT_W        = 32
) (
    input logic          clk,
    input logic          rst_n,
    run_monitor_if.slave bus
);

    localparam int SEQ_MAX = (RST_CYCLES > DRAIN_CYCLES) ? RST_CYCLES : DRAIN_CYCLES;
    localparam int SEQ_W   = (SEQ_MAX > 1) ? $clog2(SEQ_MAX) : 1;

    localparam logic [SEQ_W-1:0] RST_LOAD   = SEQ_W'(RST_CYCLES - 1);
    localparam logic [SEQ_W-1:0] DRAIN_LOAD = SEQ_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
    localparam logic [CNT_W:0]   TIMEOUT_V  = (CNT_W + 1)'(TIMEOUT);

    run_state_t           state;
    run_state_t           state_next;
    logic [SEQ_W-1:0]     seq_cnt;
    logic                 seq_load;
    logic [SEQ_W-1:0]     seq_load_val;
    logic                 seq_dec;
    logic                 clear_run;
    logic                 cyc_inc;
    logic                 set_timeout;
    logic                 run_en;
    logic                 all_halted;
    logic                 wd_hit;
    logic [CNT_W:0]       cnt_plus1;
    logic [NUM_CORES-1:0] halted_next;

    assign run_en     = (state == RUN);
    assign all_halted = &halted_next;
    assign cnt_plus1  = {1'b0, bus.cycle_cnt} + {{CNT_W{1'b0}}, 1'b1};
    assign wd_hit     = (TIMEOUT != 0) && (cnt_plus1 == TIMEOUT_V);

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
        halt_tracker u_trk (
            .clk         (clk),
            .rst_n       (rst_n),
            .clear       (clear_run),
            .enable      (run_en),
            .hlt         (bus.hlt[i]),
            .pc          (bus.pc[i*PC_W +: PC_W]),
            .halted      (bus.halted[i]),
            .halted_next (halted_next[i]),
            .halt_pc     (bus.halt_pc[i*PC_W +: PC_W])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next   = state;
        seq_load     = 1'b0;
        seq_load_val = '0;
        seq_dec      = 1'b0;
        clear_run    = 1'b0;
        cyc_inc      = 1'b0;
        set_timeout  = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_next   = RESET;
                    clear_run    = 1'b1;
                    seq_load     = 1'b1;
                    seq_load_val = RST_LOAD;
                end
            end
            RESET: begin
                if (seq_cnt == '0) begin
                    state_next = RUN;
                end else begin
                    seq_dec = 1'b1;
                end
            end
            RUN: begin
                cyc_inc = 1'b1;
                // A final halt on the watchdog edge takes priority over the timeout.
                if (all_halted) begin
                    if (DRAIN_CYCLES == 0) begin
                        state_next = DONE;
                    end else begin
                        state_next   = DRAIN;
                        seq_load     = 1'b1;
                        seq_load_val = DRAIN_LOAD;
                    end
                end else if (wd_hit) begin
                    state_next  = DONE;
                    set_timeout = 1'b1;
                end
            end
            DRAIN: begin
                if (seq_cnt == '0) begin
                    state_next = DONE;
                end else begin
                    seq_dec = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Status outputs are decoded from the next state so they change on the same edge as the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_cnt       <= '0;
            bus.cycle_cnt <= '0;
            bus.timeout   <= 1'b0;
            bus.cpu_rst_n <= 1'b0;
            bus.running   <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            bus.cpu_rst_n <= (state_next == RUN) || (state_next == DRAIN) || (state_next == DONE);
            bus.running   <= (state_next == RUN) || (state_next == DRAIN);
            bus.done      <= (state_next == DONE);

            if (seq_load) begin
                seq_cnt <= seq_load_val;
            end else if (seq_dec) begin
                seq_cnt <= seq_cnt - 1'b1;
            end

            if (clear_run) begin
                bus.cycle_cnt <= '0;
            end else if (cyc_inc && (bus.cycle_cnt != '1)) begin
                bus.cycle_cnt <= bus.cycle_cnt + 1'b1;
            end

            if (clear_run) begin
                bus.timeout <= 1'b0;
            end else if (set_timeout) begin
                bus.timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_run_monitor.sv
// Directed bench for run_monitor: two configurations, run results scored through an expectation queue.
module tb_run_monitor;
    import run_pkg::*;

    localparam int B_RST   = 4;
    localparam int B_DRAIN = 2;
    localparam int B_TO    = 50;

    typedef struct {
        logic [2:0]  halted;
        logic [47:0] halt_pc;
        logic [31:0] cyc;
        logic        to;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    run_monitor_if #(.NUM_CORES(1), .CNT_W(32)) a_if ();
    run_monitor_if #(.NUM_CORES(3), .CNT_W(32)) b_if ();

    run_monitor #(
        .NUM_CORES(1), .RST_CYCLES(1), .DRAIN_CYCLES(1), .TIMEOUT(0), .CNT_W(32)
    ) u_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (a_if.slave)
    );

    run_monitor #(
        .NUM_CORES(3), .RST_CYCLES(B_RST), .DRAIN_CYCLES(B_DRAIN), .TIMEOUT(B_TO), .CNT_W(32)
    ) u_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b_if.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_compare(input string tag, input logic [2:0] halted, input logic [47:0] hpc,
                              input logic [31:0] cyc, input logic to);
        exp_t e;
        check({tag, "_sb_depth"}, 64'(sb.size()), 64'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_halted"},    halted, e.halted);
            check({tag, "_halt_pc"},   hpc,    e.halt_pc);
            check({tag, "_cycle_cnt"}, cyc,    e.cyc);
            check({tag, "_timeout"},   to,     e.to);
        end
    endtask

    // Single-core run; the halt is sampled on RUN cycle hc. With hold, hlt stays high from before start.
    task automatic run_a(input int hc, input logic [15:0] hp, input bit hold);
        exp_t e;
        int   d;
        e.halted  = 3'b001;
        e.halt_pc = {32'h0, hp};
        e.cyc     = 32'(hc);
        e.to      = 1'b0;
        sb.push_back(e);

        a_if.hlt   = hold;
        a_if.pc    = hold ? hp : 16'h0;
        a_if.start = 1'b1;
        tick();
        a_if.start = 1'b0;
        check("a_rst_low",   a_if.cpu_rst_n, 0);
        check("a_clr_cycle", a_if.cycle_cnt, 0);
        check("a_clr_halt",  a_if.halted,    0);
        tick();
        check("a_rst_release", a_if.cpu_rst_n, 1);
        check("a_running",     a_if.running,   1);

        for (int c = 1; c <= hc; c++) begin
            a_if.hlt = (c >= hc);
            a_if.pc  = (hold || c == hc) ? hp : 16'($urandom);
            tick();
            check("a_cycle", a_if.cycle_cnt, c);
        end
        check("a_halted",    a_if.halted,  1);
        check("a_halt_pc",   a_if.halt_pc, hp);
        check("a_in_drain",  a_if.running, 1);
        check("a_not_done",  a_if.done,    0);

        a_if.hlt = 1'b0;
        a_if.pc  = 16'hbeef;
        d = 0;
        while (!a_if.done && d < 20) begin
            tick();
            d++;
        end
        check("a_drain_len",   d,            1);
        check("a_running_off", a_if.running, 0);
        sb_compare("a", {2'b00, a_if.halted}, {32'h0, a_if.halt_pc}, a_if.cycle_cnt, a_if.timeout);
    endtask

    // Three-core run; core k halts on RUN cycle hk (0 = never). A start pulse is driven on RUN cycle pulse_at.
    task automatic run_b(input int h0, input int h1, input int h2,
                         input logic [15:0] p0, input logic [15:0] p1, input logic [15:0] p2,
                         input int pulse_at);
        exp_t        e;
        int          hc[3];
        logic [15:0] hp[3];
        logic [2:0]  exp_h;
        bit          all;
        int          last;
        int          c;
        int          d;

        hc[0] = h0; hc[1] = h1; hc[2] = h2;
        hp[0] = p0; hp[1] = p1; hp[2] = p2;
        all  = 1'b1;
        last = 0;
        for (int k = 0; k < 3; k++) begin
            if (hc[k] == 0 || hc[k] > B_TO) all = 1'b0;
            else if (hc[k] > last) last = hc[k];
        end
        e.cyc     = all ? 32'(last) : 32'(B_TO);
        e.to      = !all;
        e.halted  = '0;
        e.halt_pc = '0;
        for (int k = 0; k < 3; k++) begin
            if (hc[k] != 0 && hc[k] <= int'(e.cyc)) begin
                e.halted[k]           = 1'b1;
                e.halt_pc[16*k +: 16] = hp[k];
            end
        end
        sb.push_back(e);

        b_if.hlt   = '0;
        b_if.start = 1'b1;
        tick();
        b_if.start = 1'b0;
        check("b_rst_low",   b_if.cpu_rst_n, 0);
        check("b_clr_halt",  b_if.halted,    0);
        check("b_clr_pc",    b_if.halt_pc,   0);
        check("b_clr_cycle", b_if.cycle_cnt, 0);
        check("b_clr_to",    b_if.timeout,   0);
        for (int i = 1; i < B_RST; i++) begin
            tick();
            check("b_rst_hold", b_if.cpu_rst_n, 0);
        end
        tick();
        check("b_rst_release", b_if.cpu_rst_n, 1);

        c = 0;
        while (b_if.running && !(&b_if.halted) && c < 80) begin
            c++;
            exp_h = '0;
            for (int k = 0; k < 3; k++) begin
                b_if.hlt[k]         = (hc[k] != 0 && c >= hc[k]);
                b_if.pc[16*k +: 16] = (c == hc[k]) ? hp[k] : 16'($urandom);
                exp_h[k]            = (hc[k] != 0 && c >= hc[k]);
            end
            b_if.start = (c == pulse_at);
            tick();
            check("b_halted", b_if.halted,    exp_h);
            check("b_cycle",  b_if.cycle_cnt, c);
            if (c == pulse_at) check("b_start_ignored", b_if.cpu_rst_n, 1);
        end
        b_if.start = 1'b0;
        check("b_run_edges", c, e.cyc);
        if (!e.to) begin
            check("b_in_drain", b_if.running, 1);
            check("b_not_done", b_if.done,    0);
        end

        d = 0;
        while (!b_if.done && d < 20) begin
            tick();
            d++;
        end
        check("b_drain_len", d, e.to ? 0 : B_DRAIN);
        check("b_done",      b_if.done,    1);
        check("b_stopped",   b_if.running, 0);
        b_if.hlt = '0;
        sb_compare("b", b_if.halted, b_if.halt_pc, b_if.cycle_cnt, b_if.timeout);
    endtask

    initial begin
        a_if.start = 1'b0; a_if.hlt = '0; a_if.pc = '0;
        b_if.start = 1'b0; b_if.hlt = '0; b_if.pc = '0;
        rst_n = 1'b0;
        #12;
        check("rst_a_cpu_rst_n", a_if.cpu_rst_n, 0);
        check("rst_a_running",   a_if.running,   0);
        check("rst_a_done",      a_if.done,      0);
        check("rst_a_cycle",     a_if.cycle_cnt, 0);
        check("rst_b_cpu_rst_n", b_if.cpu_rst_n, 0);
        check("rst_b_timeout",   b_if.timeout,   0);
        check("rst_b_halted",    b_if.halted,    0);
        check("rst_b_halt_pc",   b_if.halt_pc,   0);
        rst_n = 1'b1;
        tick();
        tick();
        check("idle_a_cpu_rst_n", a_if.cpu_rst_n, 0);

        // Halt sampled at edge 20 after start at edge 0.
        run_a(19, 16'h0042, 1'b0);
        // hlt already high on the first RUN cycle; restart from DONE.
        run_a(1, 16'h0777, 1'b1);

        // Staggered halts step the sticky flags 001 -> 011 -> 111.
        run_b(5, 7, 9, 16'h1000, 16'h2111, 16'h3222, 0);
        // Watchdog expiry with no halts.
        run_b(0, 0, 0, 16'h0, 16'h0, 16'h0, 0);
        // Restart from a timed-out DONE; last two halts land on the watchdog edge; start pulse mid-run.
        run_b(10, B_TO, B_TO, 16'haaaa, 16'hbbbb, 16'hcccc, 20);

        // Asynchronous reset in the middle of a run.
        b_if.start = 1'b1;
        tick();
        b_if.start = 1'b0;
        for (int i = 0; i < B_RST; i++) tick();
        b_if.hlt[0]    = 1'b1;
        b_if.pc[15:0]  = 16'h0abc;
        tick();
        tick();
        tick();
        check("mid_pre_halted", b_if.halted,    3'b001);
        check("mid_pre_cycle",  b_if.cycle_cnt, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_cpu_rst_n", b_if.cpu_rst_n, 0);
        check("mid_running",   b_if.running,   0);
        check("mid_done",      b_if.done,      0);
        check("mid_timeout",   b_if.timeout,   0);
        check("mid_cycle",     b_if.cycle_cnt, 0);
        check("mid_halted",    b_if.halted,    0);
        check("mid_halt_pc",   b_if.halt_pc,   0);
        #2;
        rst_n = 1'b1;
        b_if.hlt = '0;
        tick();
        check("mid_idle_running", b_if.running,   0);
        check("mid_idle_rst",     b_if.cpu_rst_n, 0);
        run_b(2, 3, 4, 16'h0111, 16'h0222, 16'h0333, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
